spmem_arbiter: RTL and testbench

//   Round-robin arbiter/sequencer that shares one sparse-memory port among NUM_REQ requesters.

---
 rtl/spmem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_spmem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmem_arbiter.sv
// Round-robin arbiter that shares one sparse-memory port among NUM_REQ requesters,
// sequencing each granted request through one access cycle and one response pulse.
module spmem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ-1:0]        req_write_i,
    input  logic [2*NUM_REQ-1:0]      req_size_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic                      rsp_err_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic                      cs_no,
    output logic [1:0]                we_o,
    output logic [1:0]                re_o,
    output logic [ADDR_W-1:0]         mem_waddr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    output logic [ADDR_W-1:0]         mem_raddr_o,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    output logic                      busy_o
);

    localparam int          PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          CNT_W  = 3;
    localparam int unsigned NREQ_U = NUM_REQ;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_id;
    logic                r_write;
    logic [1:0]          r_size;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [ADDR_W-1:0]   r_raddr;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_any;
    logic [PTR_W-1:0]    w_win;
    logic [PTR_W-1:0]    w_ptr_next;
    int unsigned         w_idx;
    logic                w_sel_write;
    logic [1:0]          w_sel_size;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_illegal;
    logic                w_last;

    // Scan from the pointer upward, wrapping; first valid requester wins.
    always_comb begin
        w_any       = 1'b0;
        w_win       = '0;
        w_idx       = 0;
        w_sel_write = 1'b0;
        w_sel_size  = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            w_idx = (32'(r_ptr) + i) % NREQ_U;
            if (!w_any && req_valid_i[PTR_W'(w_idx)]) begin
                w_any       = 1'b1;
                w_win       = PTR_W'(w_idx);
                w_sel_write = req_write_i[PTR_W'(w_idx)];
                w_sel_size  = req_size_i[w_idx*2 +: 2];
                w_sel_addr  = req_addr_i[w_idx*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata_i[w_idx*DATA_W +: DATA_W];
            end
        end
        case (w_sel_size)
            2'b00:   w_illegal = 1'b0;
            2'b01:   w_illegal = w_sel_addr[0];
            2'b10:   w_illegal = |w_sel_addr[1:0];
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_ptr_next = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    assign w_last     = (r_cnt == CNT_W'(RD_LAT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_err_o   = 1'b0;
        cs_no       = 1'b1;
        we_o        = '0;
        re_o        = '0;
        busy_o      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    req_ready_o[w_win] = 1'b1;
                    w_next = w_illegal ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                cs_no = 1'b0;
                if (r_write) begin
                    we_o   = r_size + 2'd1;
                    w_next = S_RESP;
                end else begin
                    re_o   = r_size + 2'd1;
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_last) w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid_o[r_id] = 1'b1;
                rsp_err_o         = r_err;
                w_next            = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Response data is loaded on the edge entering RESP so it holds between responses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr   <= '0;
            r_id    <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_raddr <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ptr   <= w_ptr_next;
                        r_id    <= w_win;
                        r_write <= w_sel_write;
                        r_size  <= w_sel_size;
                        r_err   <= w_illegal;
                        if (w_illegal) begin
                            r_rdata <= '0;
                        end else if (w_sel_write) begin
                            r_waddr <= w_sel_addr;
                            r_wdata <= w_sel_wdata;
                        end else begin
                            r_raddr <= w_sel_addr;
                        end
                    end
                end
                S_ACCESS: begin
                    r_cnt <= '0;
                    if (r_write) r_rdata <= '0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_rdata <= mem_rdata_i;
                end
                default: ;
            endcase
        end
    end

    assign mem_waddr_o = r_waddr;
    assign mem_wdata_o = r_wdata;
    assign mem_raddr_o = r_raddr;
    assign rsp_rdata_o = r_rdata;

endmodule

// File: tb/tb_spmem_arbiter.sv
// Directed bench for spmem_arbiter: three instances (RD_LAT 1, 3, 4), each with a
// small byte-addressed memory model whose read data is valid only in its latency cycle.
module tb_spmem_arbiter;

    logic        clk;
    logic [2:0]  rst_v;
    logic [3:0]  rv [3];
    logic [3:0]  wr_v;
    logic [7:0]  sz_v;
    logic [127:0] ad_v;
    logic [127:0] wd_v;

    logic [3:0]  ready [3];
    logic [3:0]  rsp_valid [3];
    logic        err [3];
    logic [31:0] rdata [3];
    logic        csn [3];
    logic [1:0]  we [3];
    logic [1:0]  re [3];
    logic [31:0] waddr [3];
    logic [31:0] wdata [3];
    logic [31:0] raddr [3];
    logic [31:0] mrd [3];
    logic        busy [3];

    int n_chk;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [7:0] a);
        case (a)
            8'h10:   return 8'hEF;
            8'h11:   return 8'hBE;
            8'h12:   return 8'hAD;
            8'h13:   return 8'hDE;
            default: return a ^ 8'h5A;
        endcase
    endfunction

    function automatic int nbytes(input logic [1:0] t);
        return (t == 2'd3) ? 4 : int'(t);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        logic [7:0]   mem [0:255];
        logic [255:0] wr_ok;
        logic [31:0]  pd [0:3];
        logic [3:0]   pv;
        logic [31:0]  rdv;
        logic [7:0]   ra;

        spmem_arbiter #(
            .NUM_REQ(4),
            .ADDR_W (32),
            .DATA_W (32),
            .RD_LAT (L)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst_v[g]),
            .req_valid_i(rv[g]),
            .req_ready_o(ready[g]),
            .req_write_i(wr_v),
            .req_size_i (sz_v),
            .req_addr_i (ad_v),
            .req_wdata_i(wd_v),
            .rsp_valid_o(rsp_valid[g]),
            .rsp_err_o  (err[g]),
            .rsp_rdata_o(rdata[g]),
            .cs_no      (csn[g]),
            .we_o       (we[g]),
            .re_o       (re[g]),
            .mem_waddr_o(waddr[g]),
            .mem_wdata_o(wdata[g]),
            .mem_raddr_o(raddr[g]),
            .mem_rdata_i(mrd[g]),
            .busy_o     (busy[g])
        );

        always_comb begin
            rdv = '0;
            ra  = '0;
            for (int b = 0; b < 4; b++) begin
                if (b < nbytes(re[g])) begin
                    ra = 8'(raddr[g] + 32'(b));
                    rdv[8*b +: 8] = wr_ok[ra] ? mem[ra] : init_byte(ra);
                end
            end
        end

        assign mrd[g] = pv[L-1] ? pd[L-1] : 32'h0BAD_F00D;

        always @(posedge clk) begin
            if (rst_v[g]) begin
                pv    <= '0;
                wr_ok <= '0;
            end else begin
                pv    <= {pv[2:0], (!csn[g] && re[g] != 2'd0)};
                pd[0] <= rdv;
                for (int j = 1; j < 4; j++) pd[j] <= pd[j-1];
                if (!csn[g] && we[g] != 2'd0) begin
                    for (int b = 0; b < 4; b++) begin
                        if (b < nbytes(we[g])) begin
                            mem[8'(waddr[g] + 32'(b))]   <= wdata[g][8*b +: 8];
                            wr_ok[8'(waddr[g] + 32'(b))] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request from start to finish; cycle 1 is the cycle after the accept edge.
    task automatic run_req(input string tag, input int g, input int id, input logic wr,
                           input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd,
                           input int e_rsp, input int e_cs, input logic [1:0] e_op,
                           input logic e_err, input logic [31:0] e_rd);
        int          rsp_c = -1;
        int          cs_n  = 0;
        logic [1:0]  op    = '0;
        logic [3:0]  rvs   = '0;
        logic        e     = 1'b0;
        logic [31:0] rd    = '0;
        logic        bz    = 1'b1;
        wr_v[id]          = wr;
        sz_v[id*2 +: 2]   = sz;
        ad_v[id*32 +: 32] = ad;
        wd_v[id*32 +: 32] = wd;
        rv[g][id] = 1'b1;
        #1;
        for (int k = 0; k < 10 && ready[g] == 4'd0; k++) tick();
        check({tag, "_ready"}, 32'(ready[g]), 32'(1 << id));
        tick();
        rv[g][id] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (!csn[g]) begin
                cs_n++;
                op = wr ? we[g] : re[g];
                check({tag, "_maddr"}, wr ? waddr[g] : raddr[g], ad);
                if (wr) check({tag, "_mwdata"}, wdata[g], wd);
            end
            if (!busy[g]) bz = 1'b0;
            if (rsp_valid[g] != 4'd0) begin
                rsp_c = c;
                rvs   = rsp_valid[g];
                e     = err[g];
                rd    = rdata[g];
                break;
            end
            tick();
        end
        check({tag, "_rsp_cycle"}, 32'(rsp_c), 32'(e_rsp));
        check({tag, "_cs_cycles"}, 32'(cs_n), 32'(e_cs));
        check({tag, "_op"}, 32'(op), 32'(e_op));
        check({tag, "_rsp_vec"}, 32'(rvs), 32'(1 << id));
        check({tag, "_err"}, 32'(e), 32'(e_err));
        check({tag, "_rdata"}, rd, e_rd);
        check({tag, "_busy"}, 32'(bz), 32'd1);
        tick();
        check({tag, "_idle"}, 32'(busy[g]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_rsp;
        int seen_cs;
        n_chk = 0;
        n_pass = 0;
        rst_v = '1;
        for (int g = 0; g < 3; g++) rv[g] = '0;
        wr_v = '0;
        sz_v = '0;
        ad_v = '0;
        wd_v = '0;
        tick();
        tick();
        rst_v = '0;
        #1;

        check("rst_cs_n", 32'(csn[0]), 32'd1);
        check("rst_we", 32'(we[0]), 32'd0);
        check("rst_re", 32'(re[0]), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst_rdata", rdata[0], 32'd0);
        check("rst_waddr", waddr[0], 32'd0);
        check("rst_raddr", raddr[0], 32'd0);
        check("rst_ready", 32'(ready[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);

        // Single word read, RD_LAT=1
        run_req("t1", 0, 1, 1'b0, 2'b10, 32'h10, 32'h0, 3, 1, 2'd3, 1'b0, 32'hDEADBEEF);

        // Byte write then read-back; half write then word read
        run_req("t3w", 0, 0, 1'b1, 2'b00, 32'h3, 32'hA5, 2, 1, 2'd1, 1'b0, 32'h0);
        run_req("t3r", 0, 0, 1'b0, 2'b00, 32'h3, 32'h0, 3, 1, 2'd1, 1'b0, 32'h000000A5);
        run_req("t3hw", 0, 1, 1'b1, 2'b01, 32'h20, 32'hFFFF1234, 2, 1, 2'd2, 1'b0, 32'h0);
        run_req("t3hr", 0, 1, 1'b0, 2'b10, 32'h20, 32'h0, 3, 1, 2'd3, 1'b0, 32'h79781234);

        // Illegal requests: misaligned half, size 11, misaligned word
        run_req("t4a", 0, 2, 1'b0, 2'b01, 32'h5, 32'h0, 1, 0, 2'd0, 1'b1, 32'h0);
        run_req("t4b", 0, 2, 1'b1, 2'b11, 32'h0, 32'h55, 1, 0, 2'd0, 1'b1, 32'h0);
        run_req("t4c", 0, 2, 1'b0, 2'b10, 32'h2, 32'h0, 1, 0, 2'd0, 1'b1, 32'h0);

        // All four requesters held valid from reset
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        wr_v = '0;
        sz_v = 8'b10101010;
        for (int i = 0; i < 4; i++) ad_v[i*32 +: 32] = 32'h10;
        rv[0] = 4'hF;
        #1;
        for (int n = 0; n < 5; n++) begin
            for (int k = 0; k < 10 && ready[0] == 4'd0; k++) tick();
            check($sformatf("t2_grant%0d", n), 32'(ready[0]), 32'(1 << (n % 4)));
            tick();
            check($sformatf("t2_noready%0d", n), 32'(ready[0]), 32'd0);
            for (int k = 0; k < 10 && rsp_valid[0] == 4'd0; k++) tick();
            check($sformatf("t2_rsp%0d", n), 32'(rsp_valid[0]), 32'(1 << (n % 4)));
            tick();
        end
        rv[0] = '0;

        // Reset during WAIT, RD_LAT=3
        sz_v[4 +: 2]  = 2'b10;
        ad_v[64 +: 32] = 32'h10;
        wr_v[2] = 1'b0;
        rv[1] = 4'b0100;
        #1;
        check("t5_ready", 32'(ready[1]), 32'd4);
        tick();
        rv[1] = '0;
        tick();
        check("t5_in_wait", 32'(busy[1] && csn[1]), 32'd1);
        rst_v[1] = 1'b1;
        tick();
        rst_v[1] = 1'b0;
        check("t5_rst_busy", 32'(busy[1]), 32'd0);
        check("t5_rst_cs_n", 32'(csn[1]), 32'd1);
        seen_rsp = 0;
        seen_cs = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid[1] != 4'd0) seen_rsp++;
            if (!csn[1]) seen_cs++;
            tick();
        end
        check("t5_no_rsp", 32'(seen_rsp), 32'd0);
        check("t5_no_cs", 32'(seen_cs), 32'd0);
        sz_v[0 +: 2] = 2'b10;
        sz_v[6 +: 2] = 2'b10;
        ad_v[0 +: 32]  = 32'h10;
        ad_v[96 +: 32] = 32'h10;
        wr_v[0] = 1'b0;
        wr_v[3] = 1'b0;
        rv[1] = 4'b1001;
        #1;
        check("t5_ptr0", 32'(ready[1]), 32'd1);
        rv[1] = '0;
        #1;
        run_req("t5_after", 1, 0, 1'b0, 2'b10, 32'h10, 32'h0, 5, 1, 2'd3, 1'b0, 32'hDEADBEEF);

        // RD_LAT=4: RESP five cycles after ACCESS
        run_req("t6", 2, 3, 1'b0, 2'b10, 32'h10, 32'h0, 6, 1, 2'd3, 1'b0, 32'hDEADBEEF);
        run_req("t6h", 2, 1, 1'b0, 2'b01, 32'h12, 32'h0, 6, 1, 2'd2, 1'b0, 32'h0000DEAD);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
